// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared stall encodings, FSM states and exception constants for pipe_ctrl
package pipe_ctrl_pkg;

    // Per-stage stop masks: bit0 PC/IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB (never stopped)
    localparam logic [4:0] STALL_NONE = 5'b00000;
    localparam logic [4:0] STALL_IF   = 5'b00001;
    localparam logic [4:0] STALL_ID   = 5'b00011;
    localparam logic [4:0] STALL_EX   = 5'b00111;
    localparam logic [4:0] STALL_MEM  = 5'b01111;

    // Controller states
    typedef logic [1:0] state_t;
    localparam state_t ST_RUN   = 2'd0;
    localparam state_t ST_STALL = 2'd1;
    localparam state_t ST_FLUSH = 2'd2;

    // Exception codes and default handler entry
    localparam logic [31:0] EXC_NONE           = 32'h0000_0000;
    localparam logic [31:0] EXC_ERET           = 32'h0000_000E;
    localparam logic [31:0] EXC_VECTOR_DEFAULT = 32'h0000_0020;

    // The latest stage asking to stop wins; it also freezes every earlier stage.
    function automatic logic [4:0] stall_decode(
        input logic req_if,
        input logic req_id,
        input logic req_ex,
        input logic req_mem
    );
        logic [4:0] mask;
        if (req_mem)     mask = STALL_MEM;
        else if (req_ex) mask = STALL_EX;
        else if (req_id) mask = STALL_ID;
        else if (req_if) mask = STALL_IF;
        else             mask = STALL_NONE;
        return mask;
    endfunction

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// rtl/pipe_ctrl_cnt.sv - stall/flush statistics counters and optional stall watchdog (PIPE_CTRL_WDOG_EN)
module pipe_ctrl_cnt #(
    parameter int WDOG_LIMIT = 1024
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_stall_active,
    input  logic        i_flush,
    output logic [31:0] o_stall_cnt,
    output logic [15:0] o_flush_cnt,
    output logic        o_wdog_timeout,
    output logic        o_wdog_flush
);

    logic [31:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    // Stall cycles wrap freely; flushes saturate so a long run never reads back as few flushes
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_stall_cnt <= '0;
            r_flush_cnt <= '0;
        end else begin
            if (i_stall_active) begin
                r_stall_cnt <= r_stall_cnt + 32'd1;
            end
            if (i_flush && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign o_stall_cnt = r_stall_cnt;
    assign o_flush_cnt = r_flush_cnt;

`ifdef PIPE_CTRL_WDOG_EN
    logic [31:0] r_wdog_cnt;
    logic        r_wdog_timeout;
    logic        r_wdog_pend;

    // Count consecutive stalled cycles; trip once at the limit and hold a flush request until taken
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wdog_cnt     <= '0;
            r_wdog_timeout <= 1'b0;
            r_wdog_pend    <= 1'b0;
        end else begin
            if (!i_stall_active) begin
                r_wdog_cnt <= '0;
            end else if (r_wdog_cnt != 32'(WDOG_LIMIT)) begin
                r_wdog_cnt <= r_wdog_cnt + 32'd1;
            end

            if (i_stall_active && (r_wdog_cnt == 32'(WDOG_LIMIT - 1)) && !r_wdog_timeout) begin
                r_wdog_timeout <= 1'b1;
                r_wdog_pend    <= 1'b1;
            end else if (i_flush) begin
                r_wdog_pend <= 1'b0;
            end
        end
    end

    assign o_wdog_timeout = r_wdog_timeout;
    assign o_wdog_flush   = r_wdog_pend;
`else
    logic [31:0] w_unused_limit;

    assign w_unused_limit = 32'(WDOG_LIMIT);
    assign o_wdog_timeout = 1'b0;
    assign o_wdog_flush   = 1'b0;
`endif

endmodule

// File: rtl/pipe_ctrl.sv
// rtl/pipe_ctrl.sv - pipeline stall/flush controller with RUN/STALL/FLUSH FSM (watchdog via PIPE_CTRL_WDOG_EN)
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] EXC_VECTOR = EXC_VECTOR_DEFAULT,
    parameter int          WDOG_LIMIT = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_if,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype_i,
    input  logic [31:0] cp0_epc_i,
    output logic [4:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic [31:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        wdog_timeout
);

    state_t r_state;
    logic   w_exc;
    logic   w_wdog_flush;
    logic   w_stall_active;

    assign w_exc          = (excepttype_i != EXC_NONE);
    assign w_stall_active = (stall != STALL_NONE);

    // Zero-latency decode: exceptions beat stalls; the cycle after a flush only IF may hold
    always_comb begin
        stall  = STALL_NONE;
        flush  = 1'b0;
        new_pc = '0;
        if (!rst) begin
            if (r_state == ST_FLUSH) begin
                // ID/EX/MEM carry bubbles now, so their requests and exception codes are stale
                stall = stallreq_if ? STALL_IF : STALL_NONE;
            end else if (w_exc) begin
                flush  = 1'b1;
                new_pc = (excepttype_i == EXC_ERET) ? cp0_epc_i : EXC_VECTOR;
            end else if (w_wdog_flush) begin
                flush  = 1'b1;
                new_pc = EXC_VECTOR;
            end else begin
                stall = stall_decode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
            end
        end
    end

    // A flush always occupies exactly one FLUSH cycle; otherwise track whether anything is stalled
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_RUN;
        end else if (flush) begin
            r_state <= ST_FLUSH;
        end else if (w_stall_active) begin
            r_state <= ST_STALL;
        end else begin
            r_state <= ST_RUN;
        end
    end

    pipe_ctrl_cnt #(
        .WDOG_LIMIT (WDOG_LIMIT)
    ) u_cnt (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_stall_active (w_stall_active),
        .i_flush        (flush),
        .o_stall_cnt    (stall_cnt),
        .o_flush_cnt    (flush_cnt),
        .o_wdog_timeout (wdog_timeout),
        .o_wdog_flush   (w_wdog_flush)
    );

endmodule

// File: tb/tb_pipe_ctrl.sv
// tb/tb_pipe_ctrl.sv - self-checking bench for pipe_ctrl with a behavioural reference model
module tb_pipe_ctrl;

    localparam int LIMIT = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stallreq_if = 1'b0;
    logic        stallreq_id = 1'b0;
    logic        stallreq_ex = 1'b0;
    logic        stallreq_mem = 1'b0;
    logic [31:0] excepttype_i = 32'h0;
    logic [31:0] cp0_epc_i = 32'h0;
    logic [4:0]  stall;
    logic        flush;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic [15:0] flush_cnt;
    logic        wdog_timeout;

    always #5 clk = ~clk;

    pipe_ctrl #(
        .EXC_VECTOR (32'h0000_0020),
        .WDOG_LIMIT (LIMIT)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_if  (stallreq_if),
        .stallreq_id  (stallreq_id),
        .stallreq_ex  (stallreq_ex),
        .stallreq_mem (stallreq_mem),
        .excepttype_i (excepttype_i),
        .cp0_epc_i    (cp0_epc_i),
        .stall        (stall),
        .flush        (flush),
        .new_pc       (new_pc),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .wdog_timeout (wdog_timeout)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model state
    bit          m_valid = 1'b0;
    bit          m_prev_flush = 1'b0;
    int unsigned m_stall_cnt = 0;
    int unsigned m_flush_cnt = 0;
    int unsigned m_wd_run = 0;
    bit          m_wd_to = 1'b0;
    bit          m_wd_pend = 1'b0;

    // Expected combinational outputs for the current inputs and model state
    task automatic model_comb(output logic [4:0] es, output logic ef, output logic [31:0] ep);
        int top;
        es = 5'd0;
        ef = 1'b0;
        ep = 32'h0;
        if (rst) return;
        if (m_prev_flush) begin
            es = stallreq_if ? 5'd1 : 5'd0;
            return;
        end
        if (excepttype_i != 32'h0) begin
            ef = 1'b1;
            ep = (excepttype_i == 32'h0E) ? cp0_epc_i : 32'h20;
            return;
        end
        if (m_wd_pend) begin
            ef = 1'b1;
            ep = 32'h20;
            return;
        end
        top = -1;
        if (stallreq_if)  top = 0;
        if (stallreq_id)  top = 1;
        if (stallreq_ex)  top = 2;
        if (stallreq_mem) top = 3;
        es = 5'((1 << (top + 1)) - 1);
    endtask

    // Advance the model at each rising edge
    always @(posedge clk) begin : model_upd
        logic [4:0]  es;
        logic        ef;
        logic [31:0] ep;
        model_comb(es, ef, ep);
        if (rst) begin
            m_valid      = 1'b1;
            m_prev_flush = 1'b0;
            m_stall_cnt  = 0;
            m_flush_cnt  = 0;
            m_wd_run     = 0;
            m_wd_to      = 1'b0;
            m_wd_pend    = 1'b0;
        end else begin
            m_prev_flush = ef;
            if (es != 5'd0) m_stall_cnt = m_stall_cnt + 1;
            if (ef && m_flush_cnt < 65535) m_flush_cnt = m_flush_cnt + 1;
`ifdef PIPE_CTRL_WDOG_EN
            if (es != 5'd0) begin
                if (m_wd_run < LIMIT) begin
                    m_wd_run = m_wd_run + 1;
                    if (m_wd_run == LIMIT && !m_wd_to) begin
                        m_wd_to   = 1'b1;
                        m_wd_pend = 1'b1;
                    end
                end
            end else begin
                m_wd_run = 0;
            end
            if (ef) m_wd_pend = 1'b0;
`endif
        end
    end

    // Compare DUT against the model on every falling edge once reset has been seen
    always @(negedge clk) begin : cmp
        logic [4:0]  es;
        logic        ef;
        logic [31:0] ep;
        if (m_valid) begin
            model_comb(es, ef, ep);
            check("m_stall", 32'(stall), 32'(es));
            check("m_flush", 32'(flush), 32'(ef));
            check("m_new_pc", new_pc, ep);
            check("m_stall_cnt", stall_cnt, m_stall_cnt);
            check("m_flush_cnt", 32'(flush_cnt), m_flush_cnt);
            check("m_wdog", 32'(wdog_timeout), 32'(m_wd_to));
        end
    end

    task automatic set_in(input bit r, input bit qi, input bit qd, input bit qe, input bit qm,
                          input logic [31:0] exc, input logic [31:0] epc);
        rst          = r;
        stallreq_if  = qi;
        stallreq_id  = qd;
        stallreq_ex  = qe;
        stallreq_mem = qm;
        excepttype_i = exc;
        cp0_epc_i    = epc;
        #2;
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset with every input active: outputs must stay quiet
        set_in(1, 1, 1, 1, 1, 32'h8, 32'h1234);
        check("rst_stall", 32'(stall), 32'h0);
        check("rst_flush", 32'(flush), 32'h0);
        check("rst_new_pc", new_pc, 32'h0);
        next_cyc();
        next_cyc();
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("rst_stall_cnt", stall_cnt, 32'h0);
        check("rst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("rst_wdog", 32'(wdog_timeout), 32'h0);
        next_cyc();

        // MEM stall held for three cycles
        for (int i = 0; i < 3; i++) begin
            set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
            check("mem_stall", 32'(stall), 32'h0F);
            next_cyc();
        end
        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        check("mem_release_stall", 32'(stall), 32'h0);
        check("mem_stall_cnt", stall_cnt, 32'd3);
        next_cyc();

        // ID and EX together: EX wins
        set_in(0, 0, 1, 1, 0, 32'h0, 32'h0);
        check("idex_stall", 32'(stall), 32'h07);
        next_cyc();

        // Exception with EX stall request
        set_in(0, 0, 0, 1, 0, 32'h8, 32'h0);
        check("exc_flush", 32'(flush), 32'h1);
        check("exc_stall", 32'(stall), 32'h0);
        check("exc_new_pc", new_pc, 32'h20);
        check("exc_stall_cnt", stall_cnt, 32'd4);
        next_cyc();
        set_in(0, 0, 0, 1, 0, 32'h8, 32'h0);
        check("flushst_flush", 32'(flush), 32'h0);
        check("flushst_stall", 32'(stall), 32'h0);
        check("flushst_flush_cnt", 32'(flush_cnt), 32'd1);
        check("flushst_stall_cnt", stall_cnt, 32'd4);
        next_cyc();

        // eret returns to EPC
        set_in(0, 0, 0, 0, 0, 32'h0E, 32'h8000_1234);
        check("eret_flush", 32'(flush), 32'h1);
        check("eret_new_pc", new_pc, 32'h8000_1234);
        next_cyc();
        set_in(0, 1, 0, 0, 0, 32'h0, 32'h0);
        check("post_eret_if", 32'(stall), 32'h01);
        check("post_eret_flush", 32'(flush), 32'h0);
        check("post_eret_flush_cnt", 32'(flush_cnt), 32'd2);
        next_cyc();

        // Reset in STALL, then reset in FLUSH
        set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
        next_cyc();
        set_in(1, 0, 0, 0, 1, 32'h0, 32'h0);
        check("rst_mid_stall", 32'(stall), 32'h0);
        next_cyc();
        set_in(0, 0, 0, 0, 0, 32'h8, 32'h0);
        check("after_rst_stall_cnt", stall_cnt, 32'h0);
        check("after_rst_flush_cnt", 32'(flush_cnt), 32'h0);
        check("after_rst_run_flush", 32'(flush), 32'h1);
        next_cyc();
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        next_cyc();
        set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
        check("rst_abort_flush_stall", 32'(stall), 32'h0F);
        check("rst_abort_flush_flush", 32'(flush), 32'h0);
        next_cyc();

        // Watchdog on a held MEM stall
        set_in(1, 0, 0, 0, 0, 32'h0, 32'h0);
        next_cyc();
`ifdef PIPE_CTRL_WDOG_EN
        for (int i = 0; i < LIMIT; i++) begin
            set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
            check("wd_pre_stall", 32'(stall), 32'h0F);
            check("wd_pre_to", 32'(wdog_timeout), 32'h0);
            next_cyc();
        end
        set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
        check("wd_to", 32'(wdog_timeout), 32'h1);
        check("wd_flush", 32'(flush), 32'h1);
        check("wd_new_pc", new_pc, 32'h20);
        check("wd_stall", 32'(stall), 32'h0);
        next_cyc();
        set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
        check("wd_flushst_stall", 32'(stall), 32'h0);
        next_cyc();
        set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
        check("wd_resume_stall", 32'(stall), 32'h0F);
        check("wd_sticky", 32'(wdog_timeout), 32'h1);
        next_cyc();
`else
        for (int i = 0; i < LIMIT + 2; i++) begin
            set_in(0, 0, 0, 0, 1, 32'h0, 32'h0);
            check("nowd_stall", 32'(stall), 32'h0F);
            check("nowd_flush", 32'(flush), 32'h0);
            next_cyc();
        end
        check("nowd_to", 32'(wdog_timeout), 32'h0);
        check("nowd_stall_cnt", stall_cnt, 32'(LIMIT + 2));
`endif

        // Randomized traffic against the model
        for (int i = 0; i < 800; i++) begin
            logic [31:0] exc;
            exc = 32'h0;
            if ($urandom_range(0, 11) == 0) begin
                exc = ($urandom_range(0, 1) == 0) ? 32'h0E : 32'($urandom_range(1, 31));
            end
            set_in($urandom_range(0, 63) == 0,
                   $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
                   $urandom_range(0, 3) == 0, $urandom_range(0, 2) == 0,
                   exc, $urandom());
            next_cyc();
        end

        set_in(0, 0, 0, 0, 0, 32'h0, 32'h0);
        next_cyc();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have parameter EXC_VECTOR, default 32'h0000_0020, common exception handler entry address.
REQ-002 SHALL have parameter WDOG_LIMIT, default 1024, number of consecutive stall cycles that trips the watchdog.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high (RstEnable = 1).
REQ-005 stallreq_if / stallreq_id / stallreq_ex / stallreq_mem  in  1 each  stall requests from the IF, ID, EX and MEM stages.
REQ-006 excepttype_i  in  32  exception code from MEM; 0 = none, 32'h0E = eret, any other nonzero = exception.
REQ-007 cp0_epc_i  in  32  current CP0 EPC, the return address for eret.
REQ-008 stall  out  5  per-stage stop, bit0 PC/IF, bit1 ID, bit2 EX, bit3 MEM, bit4 WB; 1 = Stop.
REQ-009 flush  out  1  clears all pipeline registers this cycle.
REQ-010 new_pc  out  32  redirect target, valid only while flush = 1.
REQ-011 stall_cnt  out  32  total stall cycles since reset.
REQ-012 flush_cnt  out  16  total flushes since reset.
REQ-013 wdog_timeout  out  1  sticky watchdog flag (macro-dependent, REQ-030).

Function
REQ-014 stall, flush and new_pc SHALL be combinational from the inputs and the registered state, with zero-cycle latency.
REQ-015 Stall priority SHALL be highest stage first: mem -> 5'b01111; ex -> 5'b00111; id -> 5'b00011; if -> 5'b00001; none -> 5'b00000.
REQ-016 stall[4] SHALL always be 0, so a MEM stall inserts a bubble into WB (stall[3]=1, stall[4]=0).
REQ-017 A nonzero excepttype_i in RUN or STALL SHALL assert flush, force stall = 0 and override every stall request in the same cycle.
REQ-018 new_pc SHALL be cp0_epc_i for 32'h0E, EXC_VECTOR for any other nonzero code, and 0 when flush = 0.
REQ-019 FSM states: RUN, STALL, FLUSH. State is registered.
REQ-020 RUN/STALL transitions: exception -> FLUSH; else stall != 0 -> STALL; else -> RUN.
REQ-021 FLUSH SHALL last exactly one cycle, then go to STALL if stall != 0 that cycle, else RUN.
REQ-022 In FLUSH, excepttype_i and stallreq_id/ex/mem SHALL be ignored (their stages hold flushed bubbles); only stallreq_if is honoured (stall = 5'b00001); flush = 0.
REQ-023 stall_cnt SHALL increment on every cycle with stall != 0 and wrap at 2^32.
REQ-024 flush_cnt SHALL increment on every cycle with flush = 1 and saturate at 16'hFFFF.
REQ-025 Exception and stall request in the same cycle: only the flush is counted; stall_cnt does not increment.

Reset
REQ-026 While rst = 1: stall = 0, flush = 0, new_pc = 0, regardless of inputs.
REQ-027 On a clock edge with rst = 1: state = RUN, stall_cnt = 0, flush_cnt = 0, watchdog counter = 0, wdog_timeout = 0.
REQ-028 Reset asserted in STALL or FLUSH SHALL abort the operation with no residual flush or stall on the first cycle after reset.

Configuration
REQ-029 Macro PIPE_CTRL_WDOG_EN SHALL compile the watchdog in or out.
REQ-030 With the macro defined:
- a counter increments each consecutive stall != 0 cycle and clears on any stall = 0 cycle;
- reaching WDOG_LIMIT sets wdog_timeout, which holds until reset;
- on the following cycle the controller forces a flush with new_pc = EXC_VECTOR.
REQ-031 Without the macro: no watchdog counter, wdog_timeout tied to 0, no forced flush.

Structure
REQ-032 The shared package SHALL hold the stall encodings (STALL_NONE/IF/ID/EX/MEM), the state enum, EXC_ERET = 32'h0E and the default EXC_VECTOR.
REQ-033 Counters SHALL be in one sub-module, pipe_ctrl_cnt (stall_cnt, flush_cnt, watchdog); the FSM and stall decode stay in pipe_ctrl.

Verification
REQ-034 stallreq_mem = 1 for 3 cycles, no exception -> stall = 5'b01111 for 3 cycles, stall_cnt = 3, state RUN->STALL->RUN.
REQ-035 stallreq_id and stallreq_ex = 1 together -> stall = 5'b00111 (EX wins).
REQ-036 excepttype_i = 32'h08 with stallreq_ex = 1 -> flush = 1, stall = 0, new_pc = 32'h20, flush_cnt = 1, stall_cnt unchanged; next cycle excepttype_i = 32'h08 again -> no flush (FLUSH state).
REQ-037 excepttype_i = 32'h0E, cp0_epc_i = 32'h8000_1234 -> flush = 1, new_pc = 32'h8000_1234.
REQ-038 PIPE_CTRL_WDOG_EN defined, WDOG_LIMIT = 4, stallreq_mem held -> wdog_timeout rises after the 4th stall cycle; a forced flush with new_pc = 32'h20 follows the next cycle.
REQ-039 rst = 1 asserted mid-STALL -> stall = 0 that cycle; after release all counters = 0, state RUN.
